// File: rtl/riscv_mem_pkg.sv
// Shared RV32I memory-access definitions: funct3 codes, zero word,
// load FSM state encoding and the load legality check.
package riscv_mem_pkg;

   localparam logic [2:0]  F3_LB  = 3'd0;
   localparam logic [2:0]  F3_LH  = 3'd1;
   localparam logic [2:0]  F3_LW  = 3'd2;
   localparam logic [2:0]  F3_LBU = 3'd4;
   localparam logic [2:0]  F3_LHU = 3'd5;

   localparam logic [31:0] ZERO   = 32'h0000_0000;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_REQ  = 2'd1,
      LD_DONE = 2'd2
   } load_state_t;

   // True when the load cannot be issued: unknown funct3 or a
   // halfword/word access that is not naturally aligned.
   function automatic logic load_error(input logic [2:0] f3, input logic [1:0] lane);
      logic err;
      case (f3)
         F3_LB, F3_LBU: err = 1'b0;
         F3_LH, F3_LHU: err = lane[0];
         F3_LW:         err = (lane != 2'b00);
         default:       err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword from a read word and extends it
// to 32 bits according to the load type.
module load_align
   import riscv_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   output logic [31:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection followed by sign/zero extension.
   always_comb begin
      byte_sel = 8'h00;
      case (lane)
         2'd0: byte_sel = word[7:0];
         2'd1: byte_sel = word[15:8];
         2'd2: byte_sel = word[23:16];
         2'd3: byte_sel = word[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = lane[1] ? word[31:16] : word[15:0];

      value = ZERO;
      case (funct3)
         F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   value = {{16{half_sel[15]}}, half_sel};
         F3_LW:   value = word;
         F3_LBU:  value = {24'h000000, byte_sel};
         F3_LHU:  value = {16'h0000, half_sel};
         default: value = ZERO;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// RV32I load unit: computes the effective address, issues one word read
// over a req/ack port, extracts/extends the result and reports it with a
// one-cycle rd_valid pulse (load_fault qualifies that pulse).
module load_unit
   import riscv_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        load_enable,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_value,
   input  logic [31:0] immediate12_itype,
   output logic [31:0] mem_read_address,
   output logic        mem_read_req,
   input  logic        mem_read_ack,
   input  logic [31:0] mem_read_value,
   output logic [31:0] rd_value,
   output logic        rd_valid,
   output logic        load_fault,
   output logic        busy
);

   // Count value seen on the last REQ cycle allowed without an ack.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   load_state_t state_reg;
   logic [2:0]  funct3_reg;
   logic [1:0]  lane_reg;
   logic [7:0]  timeout_count_reg;
   logic [31:0] result_reg;
   logic        fault_pending_reg;
   logic [31:0] ea;
   logic [31:0] aligned_value;

   assign ea = rs1_value + immediate12_itype;

   load_align u_align (
      .word   (mem_read_value),
      .lane   (lane_reg),
      .funct3 (funct3_reg),
      .value  (aligned_value)
   );

   // Load sequencing FSM with registered outputs; the result is staged in
   // result_reg and only published to rd_value on leaving DONE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg         <= LD_IDLE;
         funct3_reg        <= 3'd0;
         lane_reg          <= 2'd0;
         timeout_count_reg <= 8'd0;
         result_reg        <= ZERO;
         fault_pending_reg <= 1'b0;
         mem_read_address  <= ZERO;
         mem_read_req      <= 1'b0;
         rd_value          <= ZERO;
         rd_valid          <= 1'b0;
         load_fault        <= 1'b0;
         busy              <= 1'b0;
      end else begin
         rd_valid   <= 1'b0;
         load_fault <= 1'b0;
         case (state_reg)
            LD_IDLE: begin
               if (load_enable) begin
                  funct3_reg        <= funct3;
                  lane_reg          <= ea[1:0];
                  timeout_count_reg <= 8'd0;
                  busy              <= 1'b1;
                  if (load_error(funct3, ea[1:0])) begin
                     // Faulting loads never touch memory.
                     fault_pending_reg <= 1'b1;
                     result_reg        <= ZERO;
                     state_reg         <= LD_DONE;
                  end else begin
                     fault_pending_reg <= 1'b0;
                     mem_read_address  <= {ea[31:2], 2'b00};
                     mem_read_req      <= 1'b1;
                     state_reg         <= LD_REQ;
                  end
               end
            end
            LD_REQ: begin
               if (mem_read_ack) begin
                  result_reg   <= aligned_value;
                  mem_read_req <= 1'b0;
                  state_reg    <= LD_DONE;
               end else if (timeout_count_reg == TIMEOUT_LAST) begin
                  fault_pending_reg <= 1'b1;
                  result_reg        <= ZERO;
                  mem_read_req      <= 1'b0;
                  state_reg         <= LD_DONE;
               end else begin
                  timeout_count_reg <= timeout_count_reg + 8'd1;
               end
            end
            LD_DONE: begin
               rd_valid          <= 1'b1;
               load_fault        <= fault_pending_reg;
               rd_value          <= result_reg;
               timeout_count_reg <= 8'd0;
               busy              <= 1'b0;
               state_reg         <= LD_IDLE;
            end
            default: begin
               mem_read_req <= 1'b0;
               busy         <= 1'b0;
               state_reg    <= LD_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: one instance with the default timeout and
// one with TIMEOUT_CYCLES=4 for the timeout case.
module tb_load_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_enable;
   logic        le_to;
   logic [2:0]  funct3;
   logic [31:0] rs1_value;
   logic [31:0] immediate12_itype;
   logic        mem_read_ack;
   logic [31:0] mem_read_value;

   logic [31:0] addr, to_addr;
   logic        req, to_req;
   logic [31:0] rd_value, to_rd_value;
   logic        rd_valid, to_rd_valid;
   logic        load_fault, to_load_fault;
   logic        busy, to_busy;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   load_unit dut (
      .clock             (clock),
      .reset             (reset),
      .load_enable       (load_enable),
      .funct3            (funct3),
      .rs1_value         (rs1_value),
      .immediate12_itype (immediate12_itype),
      .mem_read_address  (addr),
      .mem_read_req      (req),
      .mem_read_ack      (mem_read_ack),
      .mem_read_value    (mem_read_value),
      .rd_value          (rd_value),
      .rd_valid          (rd_valid),
      .load_fault        (load_fault),
      .busy              (busy)
   );

   load_unit #(.TIMEOUT_CYCLES(4)) dut_to (
      .clock             (clock),
      .reset             (reset),
      .load_enable       (le_to),
      .funct3            (funct3),
      .rs1_value         (rs1_value),
      .immediate12_itype (immediate12_itype),
      .mem_read_address  (to_addr),
      .mem_read_req      (to_req),
      .mem_read_ack      (mem_read_ack),
      .mem_read_value    (mem_read_value),
      .rd_value          (to_rd_value),
      .rd_valid          (to_rd_valid),
      .load_fault        (to_load_fault),
      .busy              (to_busy)
   );

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic start(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm);
      funct3            = f3;
      rs1_value         = rs1;
      immediate12_itype = imm;
      load_enable       = 1'b1;
   endtask

   initial begin
      reset = 1'b1; load_enable = 1'b0; le_to = 1'b0; funct3 = 3'd0;
      rs1_value = 32'd0; immediate12_itype = 32'd0;
      mem_read_ack = 1'b0; mem_read_value = 32'd0;

      // Reset state
      step(); step();
      chk1 ("rst_req",   req,        1'b0);
      chk1 ("rst_valid", rd_valid,   1'b0);
      chk1 ("rst_fault", load_fault, 1'b0);
      chk1 ("rst_busy",  busy,       1'b0);
      chk32("rst_value", rd_value,   32'h0);
      chk32("rst_addr",  addr,       32'h0);
      reset = 1'b0;
      step();

      // LB, ack on first REQ cycle
      start(3'd0, 32'h100, 32'd3);
      mem_read_ack = 1'b1; mem_read_value = 32'h8011_2233;
      step(); load_enable = 1'b0;
      chk1 ("lb_req",   req,  1'b1);
      chk32("lb_addr",  addr, 32'h100);
      chk1 ("lb_busy",  busy, 1'b1);
      step(); mem_read_ack = 1'b0;
      chk1 ("lb_req_drop",  req,      1'b0);
      chk1 ("lb_valid_early", rd_valid, 1'b0);
      step();
      chk1 ("lb_valid", rd_valid,   1'b1);
      chk32("lb_value", rd_value,   32'hFFFF_FF80);
      chk1 ("lb_fault", load_fault, 1'b0);
      chk1 ("lb_idle",  busy,       1'b0);
      step();
      chk1 ("lb_pulse", rd_valid, 1'b0);
      chk32("lb_hold",  rd_value, 32'hFFFF_FF80);
      $display("txn LB rs1=0x100 imm=3 -> %h", rd_value);

      // LHU with negative immediate
      start(3'd5, 32'h200, 32'hFFFF_FFFE);
      mem_read_ack = 1'b1; mem_read_value = 32'hBEEF_1234;
      step(); load_enable = 1'b0;
      chk32("lhu_addr", addr, 32'h1FC);
      step(); mem_read_ack = 1'b0;
      step();
      chk1 ("lhu_valid", rd_valid, 1'b1);
      chk32("lhu_value", rd_value, 32'h0000_BEEF);
      $display("txn LHU rs1=0x200 imm=-2 -> %h", rd_value);

      // LH sign extension, lane 0
      start(3'd1, 32'h300, 32'd0);
      mem_read_ack = 1'b1; mem_read_value = 32'h1234_8001;
      step(); load_enable = 1'b0;
      step(); mem_read_ack = 1'b0;
      step();
      chk32("lh_value", rd_value, 32'hFFFF_8001);
      $display("txn LH ea=0x300 -> %h", rd_value);

      // LBU lane 1
      start(3'd4, 32'h300, 32'd1);
      mem_read_ack = 1'b1; mem_read_value = 32'h0000_F000;
      step(); load_enable = 1'b0;
      step(); mem_read_ack = 1'b0;
      step();
      chk32("lbu_value", rd_value, 32'h0000_00F0);
      $display("txn LBU ea=0x301 -> %h", rd_value);

      // Misaligned LW: no request, fault two cycles later
      start(3'd2, 32'h100, 32'd2);
      step(); load_enable = 1'b0;
      chk1 ("mis_noreq", req,  1'b0);
      chk1 ("mis_busy",  busy, 1'b1);
      step();
      chk1 ("mis_valid", rd_valid,   1'b1);
      chk1 ("mis_fault", load_fault, 1'b1);
      chk32("mis_value", rd_value,   32'h0);
      step();
      chk1 ("mis_fault_clr", load_fault, 1'b0);
      $display("txn LW ea=0x102 fault");

      // Illegal funct3 = 3
      start(3'd3, 32'h100, 32'd0);
      step(); load_enable = 1'b0;
      chk1 ("ill_noreq", req, 1'b0);
      step();
      chk1 ("ill_valid", rd_valid,   1'b1);
      chk1 ("ill_fault", load_fault, 1'b1);
      step();
      $display("txn funct3=3 fault");

      // LW with ack delayed 5 cycles; a second load_enable is ignored
      start(3'd2, 32'h400, 32'd4);
      mem_read_value = 32'hDEAD_BEEF;
      step(); load_enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk1 ("dly_req",  req,  1'b1);
         chk32("dly_addr", addr, 32'h404);
         if (i == 1) start(3'd0, 32'h800, 32'd1);
         else        load_enable = 1'b0;
         step();
      end
      chk1 ("dly_req_last", req, 1'b1);
      mem_read_ack = 1'b1;
      step(); mem_read_ack = 1'b0;
      chk1 ("dly_noearly", rd_valid, 1'b0);
      step();
      chk1 ("dly_valid", rd_valid, 1'b1);
      chk32("dly_value", rd_value, 32'hDEAD_BEEF);
      step();
      chk1 ("dly_noqueue_req",  req,  1'b0);
      chk1 ("dly_noqueue_busy", busy, 1'b0);
      $display("txn LW delayed ack -> %h", rd_value);

      // Timeout on the TIMEOUT_CYCLES=4 instance
      funct3 = 3'd2; rs1_value = 32'h500; immediate12_itype = 32'd0;
      le_to = 1'b1;
      step(); le_to = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk1("to_req_held", to_req, 1'b1);
         step();
      end
      chk1("to_req_drop", to_req,  1'b0);
      chk1("to_busy",     to_busy, 1'b1);
      step();
      chk1 ("to_valid", to_rd_valid,   1'b1);
      chk1 ("to_fault", to_load_fault, 1'b1);
      chk32("to_value", to_rd_value,   32'h0);
      step();
      $display("txn timeout fault=%b", to_load_fault);

      // Reset during REQ, then a late ack
      start(3'd0, 32'h100, 32'd0);
      step(); load_enable = 1'b0;
      chk1("rr_req_before", req, 1'b1);
      #1 reset = 1'b1;
      #1 chk1("rr_req_async", req, 1'b0);
      #1 reset = 1'b0;
      mem_read_ack = 1'b1; mem_read_value = 32'h1111_1111;
      step();
      chk1("rr_idle",    busy,     1'b0);
      chk1("rr_novalid", rd_valid, 1'b0);
      mem_read_ack = 1'b0;
      step();
      chk1 ("rr_novalid2", rd_valid, 1'b0);
      chk32("rr_value",    rd_value, 32'h0);
      $display("txn reset mid-REQ discarded");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
